// File: rtl/axioma_wdt_window.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | axioma_wdt_window: windowed watchdog with WDTCSR-style control register   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module axioma_wdt_window #(
  parameter int unsigned          CNT_W     = 21,
  parameter int unsigned          ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]    CTRL_ADDR = 'h60,
  parameter logic [ADDR_W-1:0]    WIN_ADDR  = 'h61,
  parameter int unsigned          CE_CYC    = 4,
  parameter int unsigned          RST_CYC   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [7:0]        io_data_in,
  input  logic              io_write,
  input  logic              io_read,
  output logic [7:0]        io_data_out,
  input  logic              wdr,
  input  logic              irq_ack,
  output logic              wdt_irq,
  output logic              wdt_reset,
  output logic [CNT_W-1:0]  debug_count,
  output logic [1:0]        debug_state
);

  localparam int unsigned CE_W  = $clog2(CE_CYC + 1);
  localparam int unsigned RST_W = $clog2(RST_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RST  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CE_W-1:0]    ce_cnt_q, ce_cnt_d;
  logic               wdif_q, wdif_d;
  logic               wdie_q, wdie_d;
  logic               wde_q, wde_d;
  logic [3:0]         wdp_q, wdp_d;
  logic [3:0]         win_q, win_d;
  logic               ewf_q, ewf_d;
  logic               wrf_q, wrf_d;

  logic [3:0]         wdp_eff;
  logic [4:0]         t_exp;
  logic [CNT_W-1:0]   t_max;
  logic [CNT_W-1:0]   seg;
  logic [CNT_W+3:0]   win_thr;
  logic [1:0]         mode;
  logic               ctrl_wr;
  logic               win_wr;
  logic               ce_open;
  logic               early;

  // Timeout period T-1 and the early-kick threshold (T/16)*WIN.
  always_comb begin
    wdp_eff = (wdp_q > 4'd9) ? 4'd9 : wdp_q;
    t_exp   = 5'd11 + {1'b0, wdp_eff};
    if (int'(t_exp) >= int'(CNT_W)) begin
      t_max = '1;
    end else begin
      t_max = (CNT_W'(1) << t_exp) - CNT_W'(1);
    end
    seg     = (t_max >> 4) + CNT_W'(1);
    win_thr = {4'b0, seg} * {{CNT_W{1'b0}}, win_q};
    early   = (win_q != 4'd0) && ({4'b0, count_q} < win_thr);
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rst_cnt_d = rst_cnt_q;
    ce_cnt_d  = ce_cnt_q;
    wdif_d    = wdif_q;
    wdie_d    = wdie_q;
    wde_d     = wde_q;
    wdp_d     = wdp_q;
    win_d     = win_q;
    ewf_d     = ewf_q;
    wrf_d     = wrf_q;

    mode    = {wde_q, wdie_q};
    ctrl_wr = io_write && (io_addr == CTRL_ADDR);
    win_wr  = io_write && (io_addr == WIN_ADDR);
    ce_open = (ce_cnt_q != '0);

    if (ce_open) begin
      ce_cnt_d = ce_cnt_q - 1'b1;
    end

    if (ctrl_wr && (state_q != ST_RST)) begin
      if (io_data_in[7]) begin
        wdif_d = 1'b0;
      end
      wdie_d = io_data_in[6];
      if (ce_open) begin
        wde_d    = io_data_in[3];
        wdp_d    = {io_data_in[5], io_data_in[2:0]};
        ce_cnt_d = '0;
      end else begin
        wde_d = wde_q | io_data_in[3];
        if (io_data_in[4] && io_data_in[3]) begin
          ce_cnt_d = CE_W'(CE_CYC);
        end
      end
    end

    if (win_wr) begin
      if (io_data_in[7]) ewf_d = 1'b0;
      if (io_data_in[6]) wrf_d = 1'b0;
      if (ce_open)       win_d = io_data_in[3:0];
    end

    // Acknowledge in interrupt-then-reset mode arms the reset-only behaviour.
    if (irq_ack) begin
      wdif_d = 1'b0;
      if (mode == 2'b11) begin
        wdie_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (mode != 2'b00) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mode == 2'b00) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (wdr) begin
          count_d = '0;
          if (early) begin
            ewf_d = 1'b1;
            if (wde_q) begin
              state_d   = ST_RST;
              wrf_d     = 1'b1;
              rst_cnt_d = '0;
            end
          end
        end else if (tick) begin
          if (count_q == t_max) begin
            count_d = '0;
            if ((mode == 2'b10) || ((mode == 2'b11) && wdif_q)) begin
              state_d   = ST_RST;
              wrf_d     = 1'b1;
              rst_cnt_d = '0;
            end else begin
              wdif_d = 1'b1;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_RST: begin
        count_d = '0;
        if (rst_cnt_q == RST_W'(RST_CYC - 1)) begin
          state_d   = ST_RUN;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    if (wdp_d != wdp_q) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      rst_cnt_q <= '0;
      ce_cnt_q  <= '0;
      wdif_q    <= 1'b0;
      wdie_q    <= 1'b0;
      wde_q     <= 1'b0;
      wdp_q     <= 4'd0;
      win_q     <= 4'd0;
      ewf_q     <= 1'b0;
      wrf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rst_cnt_q <= rst_cnt_d;
      ce_cnt_q  <= ce_cnt_d;
      wdif_q    <= wdif_d;
      wdie_q    <= wdie_d;
      wde_q     <= wde_d;
      wdp_q     <= wdp_d;
      win_q     <= win_d;
      ewf_q     <= ewf_d;
      wrf_q     <= wrf_d;
    end
  end

  always_comb begin
    io_data_out = 8'h00;
    if (io_read) begin
      if (io_addr == CTRL_ADDR) begin
        io_data_out = {wdif_q, wdie_q, wdp_q[3], ce_open, wde_q, wdp_q[2:0]};
      end else if (io_addr == WIN_ADDR) begin
        io_data_out = {ewf_q, wrf_q, 2'b00, win_q};
      end
    end
  end

  assign wdt_irq     = wdif_q & wdie_q;
  assign wdt_reset   = (state_q == ST_RST);
  assign debug_count = count_q;
  assign debug_state = state_q;

endmodule
`default_nettype wire

// File: doc/axioma_wdt_window.md
# axioma_wdt_window

Second-generation watchdog timer for AxiomaCore-328. It keeps the ATmega328P-style WDTCSR register and adds a parametrised counter width, a configurable reset pulse, window (early-kick) detection and an interrupt-then-reset mode. It runs on the single system clock and advances only on a one-cycle `tick` strobe from the 128 kHz prescaler. It sits on the I/O bus next to the timers and drives the reset controller and interrupt controller.

## Interface
- `CNT_W`, 21: counter width; timeout codes needing more bits saturate to 2^CNT_W ticks.
- `ADDR_W`, 8: I/O address width.
- `CTRL_ADDR`, 8'h60: control register address (WDTCSR layout).
- `WIN_ADDR`, 8'h61: window/status register address.
- `CE_CYC`, 4: change-enable window length, in clk cycles.
- `RST_CYC`, 16: width of the `wdt_reset` pulse, in clk cycles.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: count strobe, one clk cycle wide, already synchronous to `clk`.
- `io_addr` in ADDR_W: I/O address.
- `io_data_in` in 8: write data.
- `io_write` in 1: write strobe.
- `io_read` in 1: read strobe.
- `io_data_out` out 8: read data, combinational; 0 when the address is not selected or `io_read`=0.
- `wdr` in 1: WDR instruction executed (one-cycle pulse).
- `irq_ack` in 1: interrupt vector taken.
- `wdt_irq` out 1: WDIF & WDIE.
- `wdt_reset` out 1: system reset request.
- `debug_count` out CNT_W: current counter value.
- `debug_state` out 2: FSM state.

## Operation
- CTRL register: [7] WDIF (write 1 to clear), [6] WDIE, [5] WDP3, [4] WDCE, [3] WDE, [2:0] WDP2:0.
- WIN register: [7] EWF early-kick flag (write 1 to clear), [6] WRF watchdog-reset flag (sticky, write 1 to clear), [3:0] WIN.
- Timeout T = 2^(11+WDP) ticks, WDP 0..9. WDP codes 10..15 behave as 9. T is capped at 2^CNT_W.
- Modes, selected by {WDE, WDIE}:
  - 00: stopped; the counter is held at 0.
  - 01: interrupt only.
  - 10: reset only.
  - 11: interrupt then reset.
- FSM states: IDLE(0) → RUN(1) → RST(2).
  - IDLE: mode is 00. Moves to RUN when the mode becomes nonzero.
  - RUN: returns to IDLE when the mode becomes 00.
  - RST: asserts `wdt_reset` for RST_CYC cycles, then goes to RUN with count=0.
- RUN: the counter increments on each `tick`. On a tick when count==T-1:
  - count ← 0.
  - Mode 01: WDIF ← 1.
  - Mode 10: go to RST and set WRF.
  - Mode 11 with WDIF=0: WDIF ← 1.
  - Mode 11 with WDIF=1: go to RST and set WRF.
- `irq_ack` clears WDIF. In mode 11 it also clears WDIE, so the next timeout resets (mode 10 behaviour).
- `wdr` clears count to 0 immediately, tick or not.
- Window check: with WIN≠0, a `wdr` arriving while count < (T>>4)*WIN sets EWF.
  - If WDE=1, the early kick also goes to RST and sets WRF.
  - If WDE=0, it only sets EWF and clears count.
- Change-enable: a CTRL write with io_data_in[4]=1 and io_data_in[3]=1 opens a window of CE_CYC cycles.
  - The first CTRL write inside the window is applied in full (WDP, WDE, WDIE; WDIF is write 1 to clear) and closes the window.
  - WIN[3:0] is writable only while the window is open.
  - WDCE reads 1 while the window is open and clears automatically on expiry.
- Protected writes, outside the window:
  - WDIE is freely writable.
  - WDIF is write 1 to clear.
  - WDE can be set but not cleared.
  - WDP and WIN are unchanged.
- Any change to WDP clears count.

## Timing
- Reset values:
  - CTRL=0, WIN=0, count=0, state IDLE.
  - `wdt_irq`=0, `wdt_reset`=0, `io_data_out`=0.
- Flags and state are registered. WDIF is set on the timeout edge, and `wdt_irq` rises in that same cycle's registered output.
- `wdt_reset` rises on the clk edge after the timeout or early-kick edge. It stays high for exactly RST_CYC cycles.
- Simultaneous events:
  - `wdr` and the timeout tick in the same cycle: `wdr` wins; no timeout, count=0.
  - Hardware WDIF set and a write-1-to-clear in the same cycle: the set wins.
  - `irq_ack` and a WDIF set in the same cycle: the set wins.
- In RST, `wdr`, ticks and CTRL writes are ignored. Register writes are accepted but do not shorten the pulse.
- `reset_n` asserted mid-pulse drops `wdt_reset` asynchronously. All state, including WRF, returns to reset values.
- The counter wraps only via the timeout; it never overflows past T-1.

## Test plan
- Mode 01, WDP=0, tick every cycle → WDIF=1 and `wdt_irq`=1 after 2048 ticks; count back to 0; no `wdt_reset`.
- Mode 11, WDP=0, no `irq_ack` → IRQ at 2048 ticks; at 4096 ticks `wdt_reset` high for 16 cycles and WRF=1.
- Change-enable: write 0x18, wait 5 cycles, write 0x00 → WDE stays 1. Write 0x18 then 0x00 within 4 cycles → WDE=0, state IDLE.
- Window: WIN=8, WDP=0, WDE=1, `wdr` at count 500 → EWF=1 and reset pulse. `wdr` at count 1500 → count=0, no flag.
- `wdr` on the same cycle as the tick at count 2047 → no WDIF, count=0.
- `reset_n` low in cycle 5 of the reset pulse → `wdt_reset`=0 immediately; CTRL=WIN=0 after release.
